pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS-style core.
- Watches ID operands, the EX-stage load/redirect status and the MEM-stage data-memory handshake.
- Drives the enable, bubble and flush controls of PC, IF/ID, ID/EX and EX/MEM.
- Owns a small FSM that freezes the whole pipeline during multi-cycle data-memory accesses and traps on memory timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum MEM_WAIT cycles before trapping. Must be ≥2.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- id_rs  in  5  ID-stage rs field
- id_rt  in  5  ID-stage rt field
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  EX-stage instruction is a load
- ex_rt  in  5  EX-stage load destination
- ex_redirect  in  1  taken branch/bne/j/jal/jr resolved in EX
- mem_req  in  1  MEM stage performs a data-memory access
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- if_id_flush  out  1  IF/ID cleared to NOP
- id_ex_bubble  out  1  to ID/EX stall input (insert NOP)
- id_ex_flush  out  1  to ID/EX flush input
- pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB contents
- mem_err  out  1  sticky timeout trap flag
- stall_cnt  out  32  perf: bubble+freeze cycles (see Optional Feature)
- flush_cnt  out  32  perf: redirect flushes (see Optional Feature)

Behaviour:
- Reset: synchronous, active-high on `reset`. Sets state=RUN, wait_cnt=0, mem_err=0, perf counters=0.
- Control outputs are combinational from state and inputs. Defaults: pc_en=1, if_id_en=1, all others 0.
- freeze = (RUN & mem_req & !mem_ready) | (MEM_WAIT & !mem_ready) | ERR.
- load_use = ex_mem_read & ex_rt≠0 & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
- Priority, highest first:
  1. freeze: pipe_freeze=1, pc_en=0, if_id_en=0, no bubble, no flush.
  2. ex_redirect: if_id_flush=1, id_ex_flush=1, pc_en=1, id_ex_bubble=0. Redirect overrides load_use, since the dependent instruction is squashed anyway.
  3. load_use: pc_en=0, if_id_en=0, id_ex_bubble=1. Exactly one bubble per load; the next cycle sees ex_mem_read=0.
- FSM states:
  - RUN: mem_req & !mem_ready → MEM_WAIT with wait_cnt=1. A zero-wait access (mem_ready same cycle) stays in RUN with no freeze.
  - MEM_WAIT:
    - mem_ready → RUN, wait_cnt=0. Freeze drops in that same cycle and normal priority evaluation applies.
    - Else, if wait_cnt==MEM_TIMEOUT-1 → ERR.
    - Otherwise wait_cnt++.
  - ERR: mem_err=1. Permanently frozen; only reset exits.
- wait_cnt is CNT_W bits and never wraps (bounded by the timeout).
- ex_redirect/load_use arriving during freeze are held by the frozen pipeline and acted on the first unfrozen cycle.
- Reset asserted mid-MEM_WAIT or in ERR returns to RUN on the next edge; mem_req is ignored during reset.

Optional Feature:
- Macro: HAZ_PERF_EN.
- Defined:
  - stall_cnt increments every cycle with id_ex_bubble|pipe_freeze.
  - flush_cnt increments every cycle with id_ex_flush.
  - Both are 32-bit, saturate at 0xFFFFFFFF and clear on reset.
- Undefined: no counter registers exist; both ports are tied to 0.

Test Plan:
1. ex_mem_read=1, ex_rt=8, id_uses_rs=1, id_rs=8, no mem_req → one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle (ex_mem_read=0) all defaults.
2. Same as scenario 1 but ex_rt=0, or id_uses_rs=0 → no bubble; pc_en=1.
3. ex_redirect=1 together with load_use true → if_id_flush=1, id_ex_flush=1, pc_en=1, id_ex_bubble=0; flush_cnt +1 when HAZ_PERF_EN is defined.
4. mem_req=1, mem_ready low for 3 cycles then high → pipe_freeze=1 for exactly 3 cycles; state RUN after the ready cycle; stall_cnt=3.
5. mem_req=1, mem_ready never asserted, MEM_TIMEOUT=16 → ERR entered after 16 frozen cycles; mem_err=1 stays high until reset=1, after which state=RUN, mem_err=0.
6. ex_redirect=1 asserted during MEM_WAIT, mem_ready on cycle 2 → no flush while frozen; flush outputs asserted in the mem_ready cycle.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-controller bundle; the pipeline side is master, the controller is slave.
interface pipe_hazard_if;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_redirect, mem_req, mem_ready;
    logic        pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_flush, pipe_freeze, mem_err;
    logic [31:0] stall_cnt, flush_cnt;
    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, mem_req, mem_ready,
        input  pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_flush, pipe_freeze, mem_err, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_rt, ex_redirect, mem_req, mem_ready,
        output pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_flush, pipe_freeze, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/redirect hazard control plus data-memory wait/timeout freeze FSM.
// Define HAZ_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input logic clk,
    input logic reset,
    pipe_hazard_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;
    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             freeze, load_use;
    always_comb begin
        freeze   = (state == RUN && bus.mem_req && !bus.mem_ready) ||
                   (state == MEM_WAIT && !bus.mem_ready) || state == ERR;
        load_use = bus.ex_mem_read && bus.ex_rt != 5'd0 &&
                   ((bus.id_uses_rs && bus.id_rs == bus.ex_rt) || (bus.id_uses_rt && bus.id_rt == bus.ex_rt));
    end
    // Redirect squashes the dependent instruction, so it wins over load_use.
    assign bus.pipe_freeze  = freeze;
    assign bus.pc_en        = !freeze && (bus.ex_redirect || !load_use);
    assign bus.if_id_en     = !freeze && (bus.ex_redirect || !load_use);
    assign bus.if_id_flush  = !freeze && bus.ex_redirect;
    assign bus.id_ex_flush  = !freeze && bus.ex_redirect;
    assign bus.id_ex_bubble = !freeze && !bus.ex_redirect && load_use;
    assign bus.mem_err      = state == ERR;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: if (bus.mem_req && !bus.mem_ready) begin
                    state    <= MEM_WAIT;
                    wait_cnt <= CNT_W'(1);
                end
                MEM_WAIT: if (bus.mem_ready) begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state <= ERR;
                end else begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
                default: state <= ERR;
            endcase
        end
    end
`ifdef HAZ_PERF_EN
    logic [31:0] stall_q, flush_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((bus.id_ex_bubble || freeze) && stall_q != '1) stall_q <= stall_q + 32'd1;
            if (bus.id_ex_flush && flush_q != '1) flush_q <= flush_q + 32'd1;
        end
    end
    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = '0;
    assign bus.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors checked against a behavioural model every cycle plus literal expectations.
module tb_pipe_hazard_ctrl;
    localparam int TO = 16;
    logic clk = 0, reset = 1;
    int checks = 0, errors = 0;
    pipe_hazard_if bus();
    pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // Model: an access is outstanding while frozen; TO consecutive frozen cycles trap.
    logic        m_busy = 0, m_err = 0;
    int          m_n = 0;
    logic [31:0] m_stall = 0, m_flush = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // {pc_en, if_id_en, if_id_flush, id_ex_bubble, id_ex_flush, pipe_freeze}
    function automatic logic [5:0] exp_ctrl();
        logic frz, lu;
        frz = m_err || (m_busy ? !bus.mem_ready : bus.mem_req && !bus.mem_ready);
        lu  = bus.ex_mem_read && bus.ex_rt != 0 &&
              ((bus.id_uses_rs && bus.id_rs == bus.ex_rt) || (bus.id_uses_rt && bus.id_rt == bus.ex_rt));
        return frz ? 6'b000001 : bus.ex_redirect ? 6'b111010 : lu ? 6'b000100 : 6'b110000;
    endfunction
    function automatic logic [5:0] act_ctrl();
        return {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_bubble, bus.id_ex_flush, bus.pipe_freeze};
    endfunction
    function automatic logic [31:0] perf(input logic [31:0] v);
`ifdef HAZ_PERF_EN
        return v;
`else
        return v & 32'd0;
`endif
    endfunction
    always @(posedge clk) begin
        logic [5:0] e;
        if (reset) begin
            m_busy = 0; m_err = 0; m_n = 0; m_stall = 0; m_flush = 0;
        end else begin
            e = exp_ctrl();
            if ((e[2] || e[0]) && m_stall != 32'hFFFFFFFF) m_stall = m_stall + 1;
            if (e[1] && m_flush != 32'hFFFFFFFF) m_flush = m_flush + 1;
            if (!m_err) begin
                if (e[0]) begin
                    m_busy = 1;
                    m_n++;
                    if (m_n == TO) m_err = 1;
                end else begin
                    m_busy = 0;
                    m_n = 0;
                end
            end
        end
    end
    always @(negedge clk) if (!reset) begin
        chk("ctrl", 32'(act_ctrl()), 32'(exp_ctrl()));
        chk("mem_err", 32'(bus.mem_err), 32'(m_err));
        chk("stall_cnt", bus.stall_cnt, perf(m_stall));
        chk("flush_cnt", bus.flush_cnt, perf(m_flush));
    end
    task automatic apply(input logic [4:0] rs, rt, input logic urs, urt, mr, input logic [4:0] ert,
                         input logic redir, req, rdy);
        @(posedge clk); #1;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rs = urs; bus.id_uses_rt = urt;
        bus.ex_mem_read = mr; bus.ex_rt = ert; bus.ex_redirect = redir;
        bus.mem_req = req; bus.mem_ready = rdy;
        @(negedge clk);
    endtask
    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    initial begin
        bus.id_rs = 0; bus.id_rt = 0; bus.id_uses_rs = 0; bus.id_uses_rt = 0;
        bus.ex_mem_read = 0; bus.ex_rt = 0; bus.ex_redirect = 0; bus.mem_req = 1; bus.mem_ready = 0;
        repeat (2) @(posedge clk);
        #1 reset = 0; bus.mem_req = 0;
        @(negedge clk);
        chk("reset_ctrl", 32'(act_ctrl()), 32'b110000);
        chk("reset_err", 32'(bus.mem_err), 0);
        chk("reset_stall", bus.stall_cnt, 0);
        apply(8, 0, 1, 0, 1, 8, 0, 0, 0);
        chk("load_use_rs", 32'(act_ctrl()), 32'b000100);
        idle();
        chk("after_bubble", 32'(act_ctrl()), 32'b110000);
        chk("stall_1", bus.stall_cnt, perf(1));
        apply(8, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("ex_rt_zero", 32'(act_ctrl()), 32'b110000);
        apply(8, 0, 0, 0, 1, 8, 0, 0, 0);
        chk("rs_unused", 32'(act_ctrl()), 32'b110000);
        apply(0, 8, 0, 1, 1, 8, 0, 0, 0);
        chk("load_use_rt", 32'(act_ctrl()), 32'b000100);
        apply(8, 0, 1, 0, 1, 8, 1, 0, 0);
        chk("redirect_over_lu", 32'(act_ctrl()), 32'b111010);
        idle();
        chk("flush_1", bus.flush_cnt, perf(1));
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk("mem_wait_freeze", 32'(bus.pipe_freeze), 1);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("mem_ready_unfreeze", 32'(act_ctrl()), 32'b110000);
        chk("stall_5", bus.stall_cnt, perf(5));
        apply(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("zero_wait", 32'(bus.pipe_freeze), 0);
        apply(0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("redir_frozen_1", 32'(act_ctrl()), 32'b000001);
        apply(0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("redir_frozen_2", 32'(act_ctrl()), 32'b000001);
        apply(0, 0, 0, 0, 0, 0, 1, 0, 1);
        chk("redir_on_ready", 32'(act_ctrl()), 32'b111010);
        idle();
        chk("flush_2", bus.flush_cnt, perf(2));
        chk("stall_7", bus.stall_cnt, perf(7));
        for (int i = 0; i < TO; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk("timeout_no_err_yet", 32'(bus.mem_err), 0);
        end
        for (int i = 0; i < 3; i++) begin
            apply(8, 0, 1, 0, 1, 8, 1, 0, 1);
            chk("err_sticky", 32'(bus.mem_err), 1);
            chk("err_frozen", 32'(act_ctrl()), 32'b000001);
        end
        @(posedge clk); #1 reset = 1; bus.mem_req = 1; bus.mem_ready = 0;
        bus.ex_redirect = 0; bus.ex_mem_read = 0;
        @(posedge clk); #1 reset = 0; bus.mem_req = 0;
        @(negedge clk);
        chk("post_reset_err", 32'(bus.mem_err), 0);
        chk("post_reset_ctrl", 32'(act_ctrl()), 32'b110000);
        chk("post_reset_stall", bus.stall_cnt, 0);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
